note_sequencer: RTL and testbench

//  Parametrised successor of the 4-note tone FSM: N-note FCW sequencer feeding the NCO/DAC path.

---
 rtl/note_sequencer.sv | 157 +++++++++++++++
 tb/tb_note_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// N-note FCW sequencer for the NCO/DAC path: forward/reverse playback at 1x/2x tempo,
// pause, and an edit mode that nudges the selected note's FCW with saturation.
module note_sequencer #(
  parameter int CYCLES_PER_NOTE = 125_000_000,
  parameter int NUM_NOTES       = 4,
  parameter int FCW_WIDTH       = 24,
  parameter int FCW_INIT        = 1375181,
  parameter int FCW_STEP        = 1000,
  parameter int FCW_MIN         = 2750,
  parameter int FCW_MAX         = 1375181,
  localparam int AW = (NUM_NOTES > 2) ? $clog2(NUM_NOTES) : 1,
  localparam int CW = $clog2(CYCLES_PER_NOTE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           buttons,
  output logic [FCW_WIDTH-1:0] fcw,
  output logic [AW-1:0]        note_idx,
  output logic [NUM_NOTES-1:0] leds,
  output logic [1:0]           leds_state,
  output logic                 note_start
);

  typedef enum logic [1:0] {
    REGULAR = 2'b00,
    REVERSE = 2'b01,
    PAUSED  = 2'b10,
    EDIT    = 2'b11
  } state_t;

  localparam logic [CW-1:0]        LIMIT_1X   = CW'(CYCLES_PER_NOTE - 1);
  localparam logic [CW-1:0]        LIMIT_2X   = CW'(CYCLES_PER_NOTE / 2 - 1);
  localparam logic [AW-1:0]        LAST_IDX   = AW'(NUM_NOTES - 1);
  localparam logic [FCW_WIDTH-1:0] INIT_W     = FCW_WIDTH'(FCW_INIT);
  localparam logic [FCW_WIDTH-1:0] STEP_W     = FCW_WIDTH'(FCW_STEP);
  localparam logic [FCW_WIDTH-1:0] MIN_W      = FCW_WIDTH'(FCW_MIN);
  localparam logic [FCW_WIDTH-1:0] MAX_W      = FCW_WIDTH'(FCW_MAX);
  localparam logic [FCW_WIDTH:0]   INC_THRESH = (FCW_WIDTH+1)'(FCW_MAX - FCW_STEP);
  localparam logic [FCW_WIDTH:0]   DEC_THRESH = (FCW_WIDTH+1)'(FCW_MIN + FCW_STEP);

  state_t               state_reg, state_next;
  logic [AW-1:0]        note_idx_reg, note_idx_next;
  logic [CW-1:0]        dur_cnt_reg, dur_cnt_next;
  logic                 tempo_reg, tempo_next;  // 1 = 2x tempo
  logic [FCW_WIDTH-1:0] fcw_reg, fcw_next;
  logic                 note_start_reg, note_start_next;
  logic [FCW_WIDTH-1:0] notes_reg [NUM_NOTES];

  logic                 wr_en;
  logic [FCW_WIDTH-1:0] wr_data;
  logic                 press0, press1, press2, press3;
  logic [FCW_WIDTH-1:0] cur_note, inc_val, dec_val;
  logic [FCW_WIDTH:0]   cur_ext;
  logic [CW-1:0]        limit;
  logic [AW-1:0]        idx_inc, idx_dec;

  // Only the highest-priority pressed button acts in a given cycle.
  assign press0 = buttons[0];
  assign press1 = buttons[1] & ~buttons[0];
  assign press2 = buttons[2] & ~(|buttons[1:0]);
  assign press3 = buttons[3] & ~(|buttons[2:0]);

  assign cur_note = notes_reg[note_idx_reg];
  assign cur_ext  = {1'b0, cur_note};
  assign inc_val  = (cur_ext >= INC_THRESH) ? MAX_W : cur_note + STEP_W;
  assign dec_val  = (cur_ext <= DEC_THRESH) ? MIN_W : cur_note - STEP_W;
  assign limit    = tempo_reg ? LIMIT_2X : LIMIT_1X;
  assign idx_inc  = (note_idx_reg == LAST_IDX) ? '0 : note_idx_reg + AW'(1);
  assign idx_dec  = (note_idx_reg == '0) ? LAST_IDX : note_idx_reg - AW'(1);

  always_comb begin
    state_next      = state_reg;
    note_idx_next   = note_idx_reg;
    dur_cnt_next    = dur_cnt_reg;
    tempo_next      = tempo_reg;
    note_start_next = 1'b0;
    wr_en           = 1'b0;
    wr_data         = cur_note;
    fcw_next        = (state_reg == PAUSED) ? '0 : cur_note;

    case (state_reg)
      REGULAR, REVERSE: begin
        // Advance direction follows the current state even if a button changes it this cycle.
        if (dur_cnt_reg >= limit) begin
          dur_cnt_next    = '0;
          note_start_next = 1'b1;
          note_idx_next   = (state_reg == REGULAR) ? idx_inc : idx_dec;
        end else begin
          dur_cnt_next = dur_cnt_reg + CW'(1);
        end
        if (press0)      state_next = PAUSED;
        else if (press1) state_next = (state_reg == REGULAR) ? REVERSE : REGULAR;
        else if (press3) tempo_next = ~tempo_reg;
      end
      PAUSED: begin
        if (press0)      state_next = REGULAR;
        else if (press2) state_next = EDIT;
      end
      EDIT: begin
        if (press0) begin
          wr_en   = 1'b1;
          wr_data = inc_val;
        end else if (press1) begin
          wr_en   = 1'b1;
          wr_data = dec_val;
        end else if (press2) begin
          state_next = PAUSED;
        end else if (press3) begin
          note_idx_next = idx_inc;
        end
      end
      default: state_next = REGULAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= REGULAR;
      note_idx_reg   <= '0;
      dur_cnt_reg    <= '0;
      tempo_reg      <= 1'b0;
      fcw_reg        <= '0;
      note_start_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      note_idx_reg   <= note_idx_next;
      dur_cnt_reg    <= dur_cnt_next;
      tempo_reg      <= tempo_next;
      fcw_reg        <= fcw_next;
      note_start_reg <= note_start_next;
    end
  end

  // Note store is a resettable register file so a reset restores every note.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_NOTES; i++) notes_reg[i] <= INIT_W;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        if (note_idx_reg == AW'(i)) notes_reg[i] <= wr_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NOTES; gi++) begin : g_leds
      assign leds[gi] = (note_idx_reg == AW'(gi));
    end
  endgenerate

  assign fcw        = fcw_reg;
  assign note_idx   = note_idx_reg;
  assign leds_state = state_reg;
  assign note_start = note_start_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: scoreboard of expected note advances (index, period)
// popped on each note_start, plus direct checks of state, fcw and edit saturation.
module tb_note_sequencer;
  localparam int W  = 24;
  localparam int NN = 5;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    buttons = 4'b0000;
  logic [W-1:0]  fcw;
  logic [AW-1:0] note_idx;
  logic [NN-1:0] leds;
  logic [1:0]    leds_state;
  logic          note_start;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int idx;
    int period;
  } note_exp_t;
  note_exp_t sb[$];

  note_sequencer #(
    .CYCLES_PER_NOTE(8),
    .NUM_NOTES(NN),
    .FCW_WIDTH(W),
    .FCW_INIT(1000),
    .FCW_STEP(100),
    .FCW_MIN(500),
    .FCW_MAX(1200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .buttons(buttons),
    .fcw(fcw),
    .note_idx(note_idx),
    .leds(leds),
    .leds_state(leds_state),
    .note_start(note_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s obs=%0d exp=%0d", tag, obs, exp);
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk);
    buttons = b;
    @(negedge clk);
    buttons = 4'b0000;
  endtask

  task automatic wait_ns(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!note_start && cyc < 40);
    if (!note_start) begin
      vectors++;
      miscompares++;
      $error("FAIL note_start_timeout: got no pulse in %0d cycles expected one", cyc);
    end
  endtask

  task automatic push(input int idx, input int period);
    note_exp_t e;
    e.idx = idx;
    e.period = period;
    sb.push_back(e);
  endtask

  task automatic play(input int n);
    int c;
    note_exp_t e;
    for (int k = 0; k < n; k++) begin
      wait_ns(c);
      e = sb.pop_front();
      check("period", c, e.period);
      check("note_idx", note_idx, e.idx);
      check("leds", leds, 32'(1) << e.idx);
    end
  endtask

  initial begin
    int starts;
    int inc_exp[3];
    int dec_exp[6];
    logic [3:0] inc_btn[3];
    inc_exp = '{1100, 1200, 1200};
    inc_btn = '{4'b0001, 4'b0001, 4'b0101};
    dec_exp = '{900, 800, 700, 600, 500, 500};

    // Reset values
    #12;
    check("rst_fcw", fcw, 0);
    check("rst_idx", note_idx, 0);
    check("rst_leds", leds, 1);
    check("rst_state", leds_state, 0);
    check("rst_start", note_start, 0);

    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("fcw_cycle1", fcw, 1000);

    // Forward play with wrap, then up to idx 2
    push(1, 7); push(2, 8); push(3, 8); push(4, 8); push(0, 8); push(1, 8); push(2, 8);
    play(7);

    // Reverse keeps dur_cnt; wraps 0 -> 4
    press(4'b0010);
    check("state_rev", leds_state, 1);
    push(1, 7); push(0, 8); push(4, 8); push(3, 8);
    play(4);

    press(4'b0010);
    check("state_reg", leds_state, 0);
    push(4, 7);
    play(1);

    // Tempo 2x then back to 1x
    press(4'b1000);
    push(0, 3); push(1, 4); push(2, 4);
    play(3);
    press(4'b1000);
    push(3, 7); push(4, 8);
    play(2);

    // Pause: fcw mutes, b1 ignored, no advances
    press(4'b0001);
    check("state_pause", leds_state, 2);
    @(posedge clk); #1;
    check("fcw_paused", fcw, 0);
    press(4'b0010);
    check("pause_b1_ign", leds_state, 2);
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (note_start) starts++;
    end
    check("pause_hold", starts, 0);
    check("pause_idx", note_idx, 4);

    // Edit: select wraps 4 -> 0, increment saturates at MAX
    press(4'b0100);
    check("state_edit", leds_state, 3);
    press(4'b1000);
    check("edit_idx_wrap", note_idx, 0);
    for (int i = 0; i < 3; i++) begin
      press(inc_btn[i]);
      @(posedge clk); #1;
      check("edit_inc", fcw, inc_exp[i]);
    end
    check("edit_b0_b2", leds_state, 3);

    // Decrement note 1 down to MIN clamp
    press(4'b1000);
    @(posedge clk); #1;
    check("edit_sel1_fcw", fcw, 1000);
    for (int i = 0; i < 6; i++) begin
      press(4'b0010);
      @(posedge clk); #1;
      check("edit_dec", fcw, dec_exp[i]);
    end

    press(4'b0100);
    check("edit_exit", leds_state, 2);
    press(4'b0001);
    check("resume_state", leds_state, 0);
    @(posedge clk); #1;
    check("resume_fcw", fcw, 500);
    check("resume_idx", note_idx, 1);
    // dur_cnt held at 1 through pause/edit
    push(2, 6); push(3, 8); push(4, 8); push(0, 8);
    play(4);
    @(posedge clk); #1;
    check("stored_note0", fcw, 1200);

    // Edit then reset mid-edit
    press(4'b0001);
    press(4'b0100);
    press(4'b0010);
    @(posedge clk); #1;
    check("pre_rst_fcw", fcw, 1100);
    @(negedge clk) rst = 1'b0;
    #1;
    check("mid_rst_fcw", fcw, 0);
    check("mid_rst_idx", note_idx, 0);
    check("mid_rst_leds", leds, 1);
    check("mid_rst_state", leds_state, 0);
    check("mid_rst_start", note_start, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_n0", fcw, 1000);
    push(1, 7);
    play(1);
    @(posedge clk); #1;
    check("post_rst_n1", fcw, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end
endmodule
